// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider state encoding, divide-by-zero quotient.
package alu_pkg;

  localparam int ALU_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [ALU_WIDTH-1:0] ALL_ONES = '1;

endpackage

// File: rtl/alu_div_seq_if.sv
// Start/busy/done handshake and operand/result bus between the ALU top-level and the divider.
interface alu_div_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor, set the quotient bit.
module alu_div_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] shifted;
  logic           negative;

  assign shifted  = {r, q[WIDTH-1]};
  // Trial result is negative exactly when the shifted remainder is below the divisor.
  assign negative = (shifted < {1'b0, divisor});
  assign r_next   = negative ? shifted[WIDTH-1:0] : WIDTH'(shifted - {1'b0, divisor});
  assign q_next   = {q[WIDTH-2:0], ~negative};

endmodule

// File: rtl/alu_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional build macro ALU_DIV_EARLY_EXIT_EN: finish immediately when divisor > dividend.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t       state, state_next;
  logic [WIDTH-1:0] r, q, div_reg;
  logic [WIDTH-1:0] r_step, q_step;
  logic [WIDTH-1:0] quo, rem;
  logic [CNT_W-1:0] cnt;
  logic             dbz, busy, done;
  logic             accept, zero_div, early;

  // A start in DONE is accepted so the ALU can issue back-to-back divisions.
  assign accept   = bus.start && (state != CALC);
  assign zero_div = (bus.divisor == '0);
`ifdef ALU_DIV_EARLY_EXIT_EN
  assign early    = (bus.divisor > bus.dividend);
`else
  assign early    = 1'b0;
`endif

  alu_div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r),
    .q       (q),
    .divisor (div_reg),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_next = (zero_div || early) ? DONE : CALC;
        else        state_next = IDLE;
      end
      CALC:    if (cnt == CNT_W'(1)) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r       <= '0;
      q       <= '0;
      div_reg <= '0;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dbz     <= 1'b0;
    end else if (state == CALC) begin
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        quo <= q_step;
        rem <= r_step;
        dbz <= 1'b0;
      end
    end else if (accept) begin
      div_reg <= bus.divisor;
      if (zero_div) begin
        quo <= ALL_ONES;
        rem <= bus.dividend;
        dbz <= 1'b1;
      end else if (early) begin
        quo <= '0;
        rem <= bus.dividend;
        dbz <= 1'b0;
      end else begin
        r   <= '0;
        q   <= bus.dividend;
        cnt <= CNT_W'(WIDTH);
      end
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Sequential unsigned restoring divider for the 5-bit ALU; it is the inverse operation of the combinational multiplier.
- Produces quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so the ALU top-level can issue an operation and wait for the result.
- Sits beside the add, subtract, logic and multiply units; its result is muxed onto the ALU output by the opcode decoder.

Parameters:
- WIDTH, 5, operand/quotient/remainder width in bits (the ALU datapath width).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when not busy.
- dividend  input  WIDTH  unsigned dividend; latched on an accepted start.
- divisor  input  WIDTH  unsigned divisor; latched on an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; the result is valid in that cycle.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  flags that the last completed operation had divisor == 0.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal shift registers cleared.
- Reset mid-operation aborts the division; no done pulse is produced for the aborted operation.
- States:
  - IDLE: wait for start.
  - CALC: iterate.
  - DONE: present the result for one cycle.
- IDLE, start=1, divisor!=0:
  - Latch the operands, set the partial remainder R=0, load the quotient shift register Q=dividend, set the counter=WIDTH.
  - Go to CALC; busy=1 from the next cycle.
- IDLE, start=1, divisor==0:
  - Go directly to DONE.
  - quotient = all ones (2^WIDTH-1), remainder = dividend, div_by_zero=1.
- CALC, each cycle:
  - {R,Q} shifted left by 1.
  - Trial T = R - divisor, computed in WIDTH+1 bits.
  - If T is non-negative: R=T and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - counter decrements; when it reaches 0 after the update, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - quotient=Q, remainder=R[WIDTH-1:0], div_by_zero=0 for a non-zero divisor.
  - Then return to IDLE.
- Latency:
  - Normal operation: done is high WIDTH+1 cycles after the edge that accepted start (6 cycles at default).
  - Divide by zero: done is high 1 cycle after the accepting edge.
- Output holding: quotient, remainder and div_by_zero are registered and hold their values after done until the next completion or reset.
- Start while busy (CALC) is ignored; it is neither queued nor able to corrupt the operands.
- Start during DONE is accepted (back-to-back operation): the next state is CALC (or DONE for divisor 0) rather than IDLE, and operands are latched as in IDLE.
- Input changes after acceptance have no effect.
- Invariant at every done: dividend == quotient*divisor + remainder and remainder < divisor (divisor!=0).

Optional Feature:
- Macro: ALU_DIV_EARLY_EXIT_EN.
- Defined: in IDLE/DONE, an accepted start with divisor!=0 and divisor > dividend goes directly to DONE with quotient=0, remainder=dividend; done follows 1 cycle after acceptance.
- Undefined: that case runs the full WIDTH CALC iterations. Results are identical either way; only latency differs.

Decomposition:
- Shared package alu_pkg holds:
  - ALU_WIDTH=5;
  - the div state enum (IDLE, CALC, DONE);
  - localparam ALL_ONES for the divide-by-zero quotient.
- One natural sub-module: alu_div_step, a purely combinational single iteration. Inputs are R, Q and divisor; outputs are next R and next Q. It is instantiated once inside the CALC datapath.

Test Plan:
- 27 / 5 -> quotient=5, remainder=2, div_by_zero=0; done 6 cycles after the start edge, one cycle wide.
- 31 / 1 -> quotient=31, remainder=0; 0 / 7 -> quotient=0, remainder=0.
- 13 / 0 -> quotient=31, remainder=13, div_by_zero=1; done 1 cycle after start.
- 3 / 7 -> quotient=0, remainder=3. Latency is 6 cycles without ALU_DIV_EARLY_EXIT_EN and 1 cycle with it.
- Start 20/3, pulse start again with 9/2 while busy, then start 9/2 in the DONE cycle:
  - the first result is q=6, r=2;
  - the mid-busy start is ignored;
  - the second result is q=4, r=1, with done 6 cycles after the DONE-cycle start.
- Start 25/4, drive rst_n low in the 3rd CALC cycle -> all outputs 0, no done pulse. A following 25/4 gives q=6, r=1.
